// File: rtl/dflop_pkg.sv
// Shared constants and helpers for the dflop delay-line family.
// Occupancy width and default reset word live here.
package dflop_pkg;

  localparam int unsigned RESET_VAL_DEF = 0;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

  function automatic int unsigned occ_w(input int unsigned depth);
    return (clog2(depth + 1) < 1) ? 1 : clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dflop_n_reset_en.sv
// One delay-line stage: data word plus valid bit.
// Async active-low reset, sync flush, enable.
module dflop_n_reset_en
  import dflop_pkg::*;
#(
  parameter int unsigned    WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL =
    WIDTH'(RESET_VAL_DEF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d,
  output logic             q_valid,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q       <= RESET_VAL;
      q_valid <= 1'b0;
    end else if (flush) begin
      q       <= RESET_VAL;
      q_valid <= 1'b0;
    end else if (en) begin
      q       <= d;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/dflop_pipe_n_reset.sv
// WIDTH-bit, DEPTH-stage stallable delay line with
// per-stage valid bits, flush and occupancy count.
module dflop_pipe_n_reset
  import dflop_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL =
    WIDTH'(RESET_VAL_DEF),
  localparam int unsigned     OCC_W     = occ_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_1,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_1,
  output logic [OCC_W-1:0] occupancy
);

  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d0_in;

  // Bubbles carry RESET_VAL so invalid slots never hold stale data.
  assign d0_in = in_valid ? in_1 : RESET_VAL;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      dflop_n_reset_en #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .flush   (flush),
        .d_valid (in_valid),
        .d       (d0_in),
        .q_valid (v[k]),
        .q       (d[k])
      );
    end else begin : g_body
      dflop_n_reset_en #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .flush   (flush),
        .d_valid (v[k-1]),
        .d       (d[k-1]),
        .q_valid (v[k]),
        .q       (d[k])
      );
    end
  end

  assign out_1     = d[DEPTH-1];
  assign out_valid = v[DEPTH-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (en) begin
      occupancy <= occupancy
                 + OCC_W'(in_valid)
                 - OCC_W'(v[DEPTH-1]);
    end
  end

endmodule

// File: tb/tb_dflop_pipe_n_reset.sv
// Directed bench for dflop_pipe_n_reset (WIDTH=8, DEPTH=4).
// Expected values are hand-computed constants and tables.
module tb_dflop_pipe_n_reset;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned OCC_W = 3;

  logic             clk;
  logic             reset;
  logic             en;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_1;
  logic             out_valid;
  logic [WIDTH-1:0] out_1;
  logic [OCC_W-1:0] occupancy;

  int n_cmp;
  int n_err;

  dflop_pipe_n_reset #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (8'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_1      (in_1),
    .out_valid (out_valid),
    .out_1     (out_1),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic e, input logic f,
                     input logic iv, input logic [7:0] din);
    en       = e;
    flush    = f;
    in_valid = iv;
    in_1     = din;
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag, input logic [7:0] o,
                      input logic ov, input logic [2:0] oc);
    check({tag, ".out_1"}, 32'(out_1), 32'(o));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    check({tag, ".occ"}, 32'(occupancy), 32'(oc));
  endtask

  logic [7:0] b_out [7];
  logic       b_ov  [7];
  logic [2:0] b_occ [7];

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b0;
    en       = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b1;
    in_1     = 8'hFF;

    // reset held low with live input
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b1, (i % 2 == 0) ? 8'hFF : 8'h00);
      chk3("rst_hold", 8'h00, 1'b0, 3'd0);
    end

    // first word after release takes DEPTH edges
    reset = 1'b1;
    cyc(1'b1, 1'b0, 1'b1, 8'h5A);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      check("rel_early", 32'(out_valid), 32'd0);
    end
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    check("rel_word", 32'(out_1), 32'h5A);
    check("rel_valid", 32'(out_valid), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    check("rel_drain", 32'(occupancy), 32'd0);

    // streaming 01..08
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, 1'b0, 1'b1, 8'(k));
      chk3("stream", (k >= 4) ? 8'(k - 3) : 8'h00,
           (k >= 4), (k >= 4) ? 3'd4 : 3'(k));
    end

    // stall
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 8'hA1);
    cyc(1'b1, 1'b0, 1'b1, 8'hA2);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'hEE);
      chk3("stall", 8'h00, 1'b0, 3'd2);
    end
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    chk3("stall_a0", 8'h00, 1'b0, 3'd2);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    chk3("stall_a1", 8'hA1, 1'b1, 3'd2);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    chk3("stall_a2", 8'hA2, 1'b1, 3'd1);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    chk3("stall_end", 8'h00, 1'b0, 3'd0);

    // bubbles: 11, -, 33
    b_out = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h00, 8'h33, 8'h00};
    b_ov  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    b_occ = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0};
    for (int k = 0; k < 7; k++) begin
      case (k)
        0:       cyc(1'b1, 1'b0, 1'b1, 8'h11);
        1:       cyc(1'b1, 1'b0, 1'b0, 8'h55);
        2:       cyc(1'b1, 1'b0, 1'b1, 8'h33);
        default: cyc(1'b1, 1'b0, 1'b0, 8'h00);
      endcase
      chk3("bubble", b_out[k], b_ov[k], b_occ[k]);
    end

    // flush with en and in_valid on a full line
    for (int k = 0; k < 4; k++)
      cyc(1'b1, 1'b0, 1'b1, 8'(8'hC1 + k));
    chk3("full", 8'hC1, 1'b1, 3'd4);
    cyc(1'b1, 1'b1, 1'b1, 8'hFF);
    chk3("flush", 8'h00, 1'b0, 3'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      chk3("post_flush", 8'h00, 1'b0, 3'd0);
    end

    // async reset between edges
    for (int k = 0; k < 4; k++)
      cyc(1'b1, 1'b0, 1'b1, 8'(8'hD1 + k));
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    chk3("pre_arst", 8'hD2, 1'b1, 3'd3);
    #2;
    reset = 1'b0;
    #1;
    chk3("arst", 8'h00, 1'b0, 3'd0);
    @(posedge clk);
    #1;
    chk3("arst_hold", 8'h00, 1'b0, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dflop_pipe_n_reset.md
# dflop_pipe_n_reset

Parametrised successor to the single-bit D flip-flop with reset: a WIDTH-bit, DEPTH-stage registered delay line. Each stage carries a valid bit, and the line supports stall (enable), synchronous flush and an occupancy count. It sits between producer and consumer blocks wherever a fixed, stallable latency must be inserted on a data path.

## Interface
Parameters:
- WIDTH, 8: data bits per stage; ≥1.
- DEPTH, 4: number of register stages; ≥1.
- RESET_VAL, 0: value loaded into every data stage on reset, on flush, and on invalid input.

Ports (name, direction, width, meaning):
- clk, input, 1: rising-edge clock; single clock domain.
- reset, input, 1: asynchronous, active-low reset (asserted at 0).
- en, input, 1: advance enable; 1 = all stages shift, 0 = all stages hold.
- flush, input, 1: synchronous clear of all stages; takes priority over en.
- in_valid, input, 1: in_1 carries a valid word this cycle.
- in_1, input, WIDTH: input data word.
- out_valid, output, 1: valid bit of the last stage.
- out_1, output, WIDTH: data of the last stage.
- occupancy, output, OCC_W = clog2(DEPTH+1): number of stages currently holding a valid word.

## Operation
- Stage k (0..DEPTH-1) holds data d[k] and valid bit v[k]. out_1 = d[DEPTH-1]; out_valid = v[DEPTH-1]. Both are direct register outputs with no combinational path from the inputs.
- Reset (reset=0, asynchronous): all d[k] = RESET_VAL, all v[k] = 0, occupancy = 0. The block holds this state while reset stays low. Reset released mid-stream loses all in-flight words.
- Priority at each rising edge: reset > flush > en > hold.
- flush=1: all d[k] = RESET_VAL, all v[k] = 0, occupancy = 0. This applies regardless of en. The word on in_1 in that cycle is discarded.
- en=1, flush=0:
  - d[0] = in_valid ? in_1 : RESET_VAL; v[0] = in_valid.
  - d[k] = d[k-1] and v[k] = v[k-1] for k ≥ 1.
  - The word in the last stage is dropped, whether valid or not.
- en=0, flush=0: all stages hold; in_valid and in_1 are ignored.
- occupancy is a registered counter, not a combinational popcount. On an advance it updates to occupancy + in_valid − v[DEPTH-1]; on flush or reset it goes to 0; otherwise it holds.
- Invariant at all times: occupancy == popcount(v). It never exceeds DEPTH and never wraps.
- Invalid slots (bubbles) propagate as v=0 with data RESET_VAL. Their data is never X.

## Timing
- Latency: a word presented with en=1 at edge N appears on out_1 after edge N+DEPTH-1, provided en=1 on every intervening edge. Each edge with en=0 adds one cycle.
- DEPTH=1: a single register stage; out_valid follows in_valid one edge later.
- Throughput: one word per cycle while en=1.
- The block has no back-pressure output. The producer must gate in_valid on the same en it drives.
- Simultaneous flush and en: flush wins; the line is empty after the edge.
- Simultaneous in_valid and a valid output on an advance: occupancy is unchanged.

## Structure
- Shared package dflop_pkg holds:
  - the OCC_W width calculation (clog2 function);
  - the default RESET_VAL constant.
- Sub-module dflop_n_reset_en: one WIDTH-bit stage with valid bit, enable, synchronous flush and active-low asynchronous reset. It is instantiated DEPTH times through a generate loop.
- The top level contains the generate chain, stage-0 input gating and the occupancy counter.

## Test plan
- Reset: hold reset=0 with in_valid=1 and in_1=8'hFF toggling. Required: out_1 == 0, out_valid == 0, occupancy == 0 throughout. After release, the first valid word appears DEPTH edges after it is presented.
- Streaming (WIDTH=8, DEPTH=4, en=1): feed 8'h01..8'h08 on consecutive edges. Required:
  - out_1 shows 8'h01 after the 4th edge, followed by 8'h02..8'h08 on successive edges;
  - occupancy counts 1, 2, 3, 4 and then stays at 4.
- Stall: after loading 8'hA1, 8'hA2, drop en to 0 for 3 cycles with in_valid=1 and in_1=8'hEE. Required:
  - outputs and occupancy are frozen while en=0;
  - 8'hEE never appears on out_1;
  - 8'hA1 emerges 3 cycles later than it would without the stall.
- Bubbles: present the pattern valid, invalid, valid (8'h11, –, 8'h33). Required:
  - out_valid sequence is 1, 0, 1;
  - the bubble slot shows out_1 == RESET_VAL;
  - occupancy peaks at 2.
- Flush: with occupancy=4, assert flush and en together with in_valid=1 for one edge. Required: occupancy == 0 and out_valid == 0 on the next cycle, and the flushed input never emerges.
- Asynchronous reset mid-stream: with occupancy=3, drive reset=0 between clock edges. Required: outputs clear immediately, without waiting for a clock edge.
